// File: rtl/systolic_mm_engine.sv
// rtl/systolic_mm_engine.sv - output-stationary systolic matrix-multiply engine
//
// Streams K column/row operand pairs into a NUM_ROW x NUM_COL grid of
// multiply-accumulate cells, flushes the skewed wavefront, then drains the
// accumulators one result row at a time over a valid/ready handshake.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   start, k_len       begin a job (IDLE only); inner length K (0 means 1)
//   accumulate         1 = sum onto held results, 0 = clear at start
//   in_valid/in_ready  operand vector handshake (left_inputs = A column k,
//                      top_inputs = B row k, element i at slice i)
//   out_valid/out_ready result row handshake; out_row_idx, out_data
//   busy, done         not-IDLE flag; one-cycle completion pulse
//   cycles_count       clocks from start acceptance to done
module systolic_mm_engine #(
    parameter int NUM_ROW       = 4,
    parameter int NUM_COL       = 4,
    parameter int IN_WORD_SIZE  = 8,
    parameter int OUT_WORD_SIZE = 24,
    parameter int K_WIDTH       = 8,
    localparam int ROW_W        = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [K_WIDTH-1:0]               k_len,
    input  logic                             accumulate,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_ROW*IN_WORD_SIZE-1:0]  left_inputs,
    input  logic [NUM_COL*IN_WORD_SIZE-1:0]  top_inputs,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [ROW_W-1:0]                 out_row_idx,
    output logic [NUM_COL*OUT_WORD_SIZE-1:0] out_data,
    output logic                             busy,
    output logic                             done,
    output logic [OUT_WORD_SIZE-1:0]         cycles_count
);

    localparam int FLUSH_LEN = NUM_ROW + NUM_COL - 1;
    localparam int FLUSH_W   = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, FLUSH, DRAIN, DONE} state_t;

    state_t               state_q, state_d;
    logic [K_WIDTH-1:0]   k_lat;
    logic [K_WIDTH-1:0]   k_cnt;
    logic [FLUSH_W-1:0]   flush_cnt;
    logic [ROW_W-1:0]     row_cnt;
    logic                 accept;
    logic                 clear_acc;

    // Operand entering PE(r,c) and each PE's accumulator.
    logic [IN_WORD_SIZE-1:0]  a_bus  [NUM_ROW][NUM_COL];
    logic [IN_WORD_SIZE-1:0]  b_bus  [NUM_ROW][NUM_COL];
    logic [OUT_WORD_SIZE-1:0] acc_w  [NUM_ROW][NUM_COL];
    logic [IN_WORD_SIZE-1:0]  feed_a [NUM_ROW];
    logic [IN_WORD_SIZE-1:0]  feed_b [NUM_COL];

    assign in_ready    = (state_q == LOAD);
    assign accept      = in_valid && in_ready;
    assign clear_acc   = (state_q == IDLE) && start && !accumulate;
    assign out_valid   = (state_q == DRAIN);
    assign out_row_idx = row_cnt;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start) state_d = LOAD;
            LOAD:  if (accept && (k_cnt == k_lat - 1'b1)) state_d = FLUSH;
            FLUSH: if (flush_cnt == FLUSH_W'(FLUSH_LEN - 1)) state_d = DRAIN;
            DRAIN: if (out_ready && (row_cnt == ROW_W'(NUM_ROW - 1))) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_lat        <= '0;
            k_cnt        <= '0;
            flush_cnt    <= '0;
            row_cnt      <= '0;
            cycles_count <= '0;
        end else begin
            if (state_q == IDLE && start) begin
                k_lat        <= (k_len == '0) ? K_WIDTH'(1) : k_len;
                k_cnt        <= '0;
                cycles_count <= '0;
            end else if (state_q != IDLE && state_q != DONE) begin
                cycles_count <= cycles_count + 1'b1;
            end
            if (accept) k_cnt <= k_cnt + 1'b1;
            flush_cnt <= (state_q == FLUSH) ? flush_cnt + 1'b1 : '0;
            if (state_q == DRAIN) begin
                if (out_ready)
                    row_cnt <= (row_cnt == ROW_W'(NUM_ROW - 1)) ? '0 : row_cnt + 1'b1;
            end else begin
                row_cnt <= '0;
            end
        end
    end

    // Bubbles and non-LOAD cycles inject zeros, which leave accumulators untouched.
    always_comb begin
        for (int r = 0; r < NUM_ROW; r++)
            feed_a[r] = accept ? left_inputs[r*IN_WORD_SIZE +: IN_WORD_SIZE] : '0;
        for (int c = 0; c < NUM_COL; c++)
            feed_b[c] = accept ? top_inputs[c*IN_WORD_SIZE +: IN_WORD_SIZE] : '0;
    end

    // Row r is delayed r cycles so A(r,k) meets B(k,c) in PE(r,c).
    for (genvar gr = 0; gr < NUM_ROW; gr++) begin : g_row_skew
        if (gr == 0) begin : g_direct
            assign a_bus[gr][0] = feed_a[gr];
        end else begin : g_delay
            logic [IN_WORD_SIZE-1:0] sh [gr];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < gr; i++) sh[i] <= '0;
                end else begin
                    sh[0] <= feed_a[gr];
                    for (int i = 1; i < gr; i++) sh[i] <= sh[i-1];
                end
            end
            assign a_bus[gr][0] = sh[gr-1];
        end
    end

    for (genvar gc = 0; gc < NUM_COL; gc++) begin : g_col_skew
        if (gc == 0) begin : g_direct
            assign b_bus[0][gc] = feed_b[gc];
        end else begin : g_delay
            logic [IN_WORD_SIZE-1:0] sh [gc];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < gc; i++) sh[i] <= '0;
                end else begin
                    sh[0] <= feed_b[gc];
                    for (int i = 1; i < gc; i++) sh[i] <= sh[i-1];
                end
            end
            assign b_bus[0][gc] = sh[gc-1];
        end
    end

    for (genvar gr = 0; gr < NUM_ROW; gr++) begin : g_pe_row
        for (genvar gc = 0; gc < NUM_COL; gc++) begin : g_pe_col
            logic [OUT_WORD_SIZE-1:0] acc_q;
            logic [OUT_WORD_SIZE-1:0] prod;
            assign prod = OUT_WORD_SIZE'(a_bus[gr][gc]) * OUT_WORD_SIZE'(b_bus[gr][gc]);

            always_ff @(posedge clk or negedge rst) begin
                if (!rst)           acc_q <= '0;
                else if (clear_acc) acc_q <= '0;
                else                acc_q <= acc_q + prod;
            end
            assign acc_w[gr][gc] = acc_q;

            // Edge cells have no neighbour to forward to.
            if (gc < NUM_COL - 1) begin : g_fwd_a
                logic [IN_WORD_SIZE-1:0] a_q;
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) a_q <= '0;
                    else      a_q <= a_bus[gr][gc];
                end
                assign a_bus[gr][gc+1] = a_q;
            end
            if (gr < NUM_ROW - 1) begin : g_fwd_b
                logic [IN_WORD_SIZE-1:0] b_q;
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) b_q <= '0;
                    else      b_q <= b_bus[gr][gc];
                end
                assign b_bus[gr+1][gc] = b_q;
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int c = 0; c < NUM_COL; c++)
            out_data[c*OUT_WORD_SIZE +: OUT_WORD_SIZE] = acc_w[row_cnt][c];
    end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// tb/tb_systolic_mm_engine.sv - scoreboard bench for systolic_mm_engine
module tb_systolic_mm_engine;

    localparam int NR   = 4;
    localparam int NC   = 4;
    localparam int IW   = 8;
    localparam int OW   = 16;
    localparam int KW   = 8;
    localparam int KMAX = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [KW-1:0]     k_len;
    logic              accumulate;
    logic              in_valid;
    logic              in_ready;
    logic [NR*IW-1:0]  left_inputs;
    logic [NC*IW-1:0]  top_inputs;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        out_row_idx;
    logic [NC*OW-1:0]  out_data;
    logic              busy;
    logic              done;
    logic [OW-1:0]     cycles_count;

    always #5 clk = ~clk;

    systolic_mm_engine #(
        .NUM_ROW(NR), .NUM_COL(NC), .IN_WORD_SIZE(IW),
        .OUT_WORD_SIZE(OW), .K_WIDTH(KW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .accumulate(accumulate), .in_valid(in_valid), .in_ready(in_ready),
        .left_inputs(left_inputs), .top_inputs(top_inputs),
        .out_valid(out_valid), .out_ready(out_ready), .out_row_idx(out_row_idx),
        .out_data(out_data), .busy(busy), .done(done), .cycles_count(cycles_count)
    );

    int checks = 0;
    int passes = 0;
    int done_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference model: plain matrix arithmetic on held accumulators.
    int unsigned   m_acc [NR][NC];
    logic [IW-1:0] a_m [NR][KMAX];
    logic [IW-1:0] b_m [KMAX][NC];

    typedef struct {
        int               idx;
        logic [NC*OW-1:0] data;
    } row_t;

    row_t        exp_q[$];
    int unsigned cyc_q[$];

    task automatic model_job(input int k, input bit acc);
        row_t rw;
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++) begin
                int unsigned s;
                s = acc ? m_acc[r][c] : 0;
                for (int i = 0; i < k; i++) s += a_m[r][i] * b_m[i][c];
                m_acc[r][c] = s % (1 << OW);
            end
        for (int r = 0; r < NR; r++) begin
            rw.idx  = r;
            rw.data = '0;
            for (int c = 0; c < NC; c++) rw.data[c*OW +: OW] = OW'(m_acc[r][c]);
            exp_q.push_back(rw);
        end
    endtask

    task automatic fill_const(input int av, input int bv);
        for (int r = 0; r < NR; r++) for (int i = 0; i < KMAX; i++) a_m[r][i] = IW'(av);
        for (int i = 0; i < KMAX; i++) for (int c = 0; c < NC; c++) b_m[i][c] = IW'(bv);
    endtask

    task automatic fill_rand();
        for (int r = 0; r < NR; r++) for (int i = 0; i < KMAX; i++) a_m[r][i] = IW'($urandom);
        for (int i = 0; i < KMAX; i++) for (int c = 0; c < NC; c++) b_m[i][c] = IW'($urandom);
    endtask

    task automatic wait_idle(input string name);
        bit ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        if (!ok) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic drive_vector(input int i);
        logic [NR*IW-1:0] lv;
        logic [NC*IW-1:0] tv;
        for (int r = 0; r < NR; r++) lv[r*IW +: IW] = a_m[r][i];
        for (int c = 0; c < NC; c++) tv[c*IW +: IW] = b_m[i][c];
        in_valid = 1; left_inputs = lv; top_inputs = tv;
        @(negedge clk);
        check("in_ready_load", in_ready, 1);
        @(posedge clk); #1;
    endtask

    // bub_mode: 0 none, 1 bubble between every vector, 2 random bubbles.
    task automatic run_job(input int kfield, input int k, input bit acc,
                           input int bub_mode, input int stall, input bit hold_start);
        bit          bub [KMAX];
        int          nbub = 0;
        int          d0;
        int unsigned exp_cyc;
        bit          seen = 0;
        for (int i = 0; i < k; i++) begin
            bub[i] = (i > 0) && ((bub_mode == 1) || (bub_mode == 2 && $urandom_range(0, 1) == 1));
            nbub += int'(bub[i]);
        end
        wait_idle("idle_before_job");
        model_job(k, acc);
        exp_cyc = k + nbub + (NR + NC - 1) + NR + stall;
        cyc_q.push_back(exp_cyc);
        d0 = done_cnt;
        @(posedge clk); #1;
        start = 1; k_len = KW'(kfield); accumulate = acc; out_ready = (stall == 0);
        @(posedge clk); #1;
        if (!hold_start) start = 0;
        for (int i = 0; i < k; i++) begin
            if (bub[i]) begin
                in_valid = 0; left_inputs = NR*IW'($urandom); top_inputs = NC*IW'($urandom);
                @(posedge clk); #1;
            end
            drive_vector(i);
        end
        in_valid = 0; start = 0;
        left_inputs = NR*IW'($urandom); top_inputs = NC*IW'($urandom);
        if (stall > 0) begin
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (out_valid) begin seen = 1; break; end
            end
            if (!seen) check("out_valid_timeout", 0, 1);
            repeat (stall) @(posedge clk);
            #1 out_ready = 1;
        end
        wait_idle("job_finish");
        check("done_pulses", done_cnt - d0, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("cycles_hold_idle", cycles_count, exp_cyc);
    endtask

    // Monitor: pops expected rows on every result handshake.
    logic [NC*OW-1:0] prev_data;
    logic [1:0]       prev_idx;
    bit               prev_stall = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (out_valid) begin
                if (prev_stall) begin
                    check("stall_data_stable", out_data, prev_data);
                    check("stall_idx_stable", out_row_idx, prev_idx);
                end
                if (out_ready) begin
                    if (exp_q.size() == 0) check("unexpected_row", 1, 0);
                    else begin
                        row_t e;
                        e = exp_q.pop_front();
                        check("row_idx", out_row_idx, e.idx);
                        check("row_data", out_data, e.data);
                    end
                end
                prev_stall = !out_ready;
                prev_data  = out_data;
                prev_idx   = out_row_idx;
            end else begin
                prev_stall = 0;
            end
            if (done) begin
                done_cnt++;
                if (cyc_q.size() == 0) check("unexpected_done", 1, 0);
                else check("cycles_count", cycles_count, cyc_q.pop_front());
            end
        end else begin
            prev_stall = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int d0;
        rst = 0; start = 0; k_len = '0; accumulate = 0; in_valid = 0;
        out_ready = 1; left_inputs = '0; top_inputs = '0;
        for (int r = 0; r < NR; r++) for (int c = 0; c < NC; c++) m_acc[r][c] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_row_idx", out_row_idx, 0);
        check("rst_cycles", cycles_count, 0);
        @(posedge clk); #1 rst = 1;

        // Uniform 2x3 job, then accumulate onto it, then clear.
        fill_const(2, 3);
        run_job(1, 1, 0, 0, 0, 0);
        run_job(1, 1, 1, 0, 0, 0);
        run_job(1, 1, 0, 0, 0, 0);

        // Identity A selects rows of B.
        for (int r = 0; r < NR; r++) for (int i = 0; i < KMAX; i++) a_m[r][i] = IW'(r == i);
        for (int i = 0; i < KMAX; i++) for (int c = 0; c < NC; c++) b_m[i][c] = IW'((c + 1) * (i + 1));
        run_job(4, 4, 0, 0, 0, 0);

        // Bubbles during LOAD and a five-cycle drain stall.
        fill_rand();
        run_job(4, 4, 0, 1, 5, 0);

        // Accumulator wrap modulo 2^OW.
        fill_const(255, 255);
        run_job(2, 2, 0, 0, 0, 0);

        // Randomized jobs, start held high while busy in some.
        for (int j = 0; j < 6; j++) begin
            int k;
            k = $urandom_range(1, KMAX);
            fill_rand();
            run_job(k, k, bit'($urandom_range(0, 1)), 2, $urandom_range(0, 3),
                    bit'($urandom_range(0, 1)));
        end

        // Reset mid-FLUSH aborts the job with no done pulse.
        fill_rand();
        wait_idle("idle_before_abort");
        d0 = done_cnt;
        @(posedge clk); #1;
        start = 1; k_len = 2; accumulate = 1;
        @(posedge clk); #1 start = 0;
        drive_vector(0);
        drive_vector(1);
        in_valid = 0;
        @(posedge clk);
        @(negedge clk);
        check("busy_in_flush", busy, 1);
        @(posedge clk); #3 rst = 0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_cycles", cycles_count, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1;
        check("abort_no_done_pulse", done_cnt - d0, 0);
        for (int r = 0; r < NR; r++) for (int c = 0; c < NC; c++) m_acc[r][c] = 0;
        // k_len=0 runs as K=1; accumulate=1 exposes any leftover accumulator state.
        fill_rand();
        run_job(0, 1, 1, 0, 0, 0);

        check("rows_outstanding", exp_q.size(), 0);
        check("done_outstanding", cyc_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
